// File: rtl/axis_credit_based_shaper.sv
// ============================================================================
// Module   : axis_credit_based_shaper
// Purpose  : Credit-based shaper for one AXI4-Stream traffic class. Frames pass
//            through with zero latency while credit allows. A frame that has
//            started is never cut by the gate.
// Option   : CBS_IDLE_CREDIT_RESET_EN - when defined, positive credit is
//            discarded while the queue is empty. When undefined, idle time
//            banks credit up to max_credit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_credit_based_shaper #(
  parameter int C_AXIS_TDATA_WIDTH = 8,
  parameter int C_AXIS_TKEEP_WIDTH = C_AXIS_TDATA_WIDTH / 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic signed [31:0]            idle_slope,
  input  logic signed [31:0]            send_slope,
  input  logic signed [31:0]            max_credit,
  input  logic signed [31:0]            min_credit,
  output logic signed [31:0]            credit,
  output logic                          transmit_until_frame_end,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [C_AXIS_TKEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [C_AXIS_TKEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast
);

  logic signed [31:0] credit_q, credit_d;
  logic               in_frame_q, in_frame_d;
  logic               gate_open;
  logic               xfer;
  logic signed [32:0] credit_ext, idle_ext, send_ext, max_ext, min_ext;
  logic signed [32:0] sum;

  // Registered credit only: a beat that drives credit negative still completes.
  assign gate_open = in_frame_q | ~credit_q[31];

  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tkeep  = s_axis_tkeep;
  assign m_axis_tlast  = s_axis_tlast;
  assign m_axis_tvalid = s_axis_tvalid & gate_open & rstn;
  assign s_axis_tready = m_axis_tready & gate_open & rstn;
  assign xfer          = m_axis_tvalid & m_axis_tready;

  assign credit                   = credit_q;
  assign transmit_until_frame_end = in_frame_q;

  assign credit_ext = 33'(credit_q);
  assign idle_ext   = 33'(idle_slope);
  assign send_ext   = 33'(send_slope);
  assign max_ext    = 33'(max_credit);
  assign min_ext    = 33'(min_credit);

  always_comb begin
    sum        = credit_ext;
    in_frame_d = in_frame_q;
    if (xfer) begin
      sum        = credit_ext + send_ext;
      in_frame_d = ~s_axis_tlast;
    end else if (s_axis_tvalid) begin
      sum = credit_ext + idle_ext;
    end else if (credit_q[31]) begin
      // Empty queue recovers negative credit, but never past zero.
      sum = credit_ext + idle_ext;
      if (sum > 33'sd0) begin
        sum = 33'sd0;
      end
    end else begin
`ifdef CBS_IDLE_CREDIT_RESET_EN
      sum = 33'sd0;
`else
      sum = credit_ext + idle_ext;
`endif
    end

    if (sum > max_ext) begin
      credit_d = max_credit;
    end else if (sum < min_ext) begin
      credit_d = min_credit;
    end else begin
      credit_d = sum[31:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      credit_q   <= '0;
      in_frame_q <= 1'b0;
    end else begin
      credit_q   <= credit_d;
      in_frame_q <= in_frame_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axis_credit_based_shaper.sv
// ============================================================================
// Module   : tb_axis_credit_based_shaper
// Purpose  : Directed self-checking bench for axis_credit_based_shaper.
//            Expected values follow CBS_IDLE_CREDIT_RESET_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_credit_based_shaper;

  logic               clk;
  logic               rstn;
  logic signed [31:0] idle_slope, send_slope, max_credit, min_credit;
  logic signed [31:0] credit;
  logic               tufe;
  logic [7:0]         s_tdata, m_tdata;
  logic [0:0]         s_tkeep, m_tkeep;
  logic               s_tvalid, s_tready, s_tlast;
  logic               m_tvalid, m_tready, m_tlast;

  int checks = 0;
  int errors = 0;

  axis_credit_based_shaper #(
    .C_AXIS_TDATA_WIDTH(8),
    .C_AXIS_TKEEP_WIDTH(1)
  ) dut (
    .clk                      (clk),
    .rstn                     (rstn),
    .idle_slope               (idle_slope),
    .send_slope               (send_slope),
    .max_credit               (max_credit),
    .min_credit               (min_credit),
    .credit                   (credit),
    .transmit_until_frame_end (tufe),
    .s_axis_tdata             (s_tdata),
    .s_axis_tkeep             (s_tkeep),
    .s_axis_tvalid            (s_tvalid),
    .s_axis_tready            (s_tready),
    .s_axis_tlast             (s_tlast),
    .m_axis_tdata             (m_tdata),
    .m_axis_tkeep             (m_tkeep),
    .m_axis_tvalid            (m_tvalid),
    .m_axis_tready            (m_tready),
    .m_axis_tlast             (m_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drive, check pass-through, clock once, check state,
  // and return at the following negedge.
  task automatic cyc(input string tag, input logic v, input logic [7:0] d, input logic l,
                     input logic rdy, input logic exp_mv, input logic exp_sr,
                     input int exp_cr, input logic exp_tu);
    s_tvalid = v;
    s_tdata  = d;
    s_tlast  = l;
    s_tkeep  = 1'b1;
    m_tready = rdy;
    #1;
    chk({tag, ".mvalid"}, 32'(m_tvalid), 32'(exp_mv));
    chk({tag, ".sready"}, 32'(s_tready), 32'(exp_sr));
    if (exp_mv) begin
      chk({tag, ".mdata"}, 32'(m_tdata), 32'(d));
      chk({tag, ".mlast"}, 32'(m_tlast), 32'(l));
      chk({tag, ".mkeep"}, 32'(m_tkeep), 32'd1);
    end
    @(posedge clk);
    #1;
    chk({tag, ".credit"}, credit, exp_cr);
    chk({tag, ".tufe"}, 32'(tufe), 32'(exp_tu));
    @(negedge clk);
  endtask

  int exp_cr;

  initial begin
    idle_slope = 32'sd1;
    send_slope = -32'sd1;
    max_credit = 32'h7FFF_FFFF;
    min_credit = 32'h8000_0000;
    rstn       = 1'b0;
    s_tvalid   = 1'b1;
    s_tdata    = 8'hA0;
    s_tkeep    = 1'b1;
    s_tlast    = 1'b0;
    m_tready   = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.credit", credit, 32'd0);
    chk("rst.mvalid", 32'(m_tvalid), 32'd0);
    chk("rst.sready", 32'(s_tready), 32'd0);
    chk("rst.tufe", 32'(tufe), 32'd0);
    rstn = 1'b1;

    // Single 4-beat frame from zero credit
    cyc("a0", 1, 8'hA0, 0, 1, 1, 1, -1, 1);
    cyc("a1", 1, 8'hA1, 0, 1, 1, 1, -2, 1);
    cyc("a2", 1, 8'hA2, 0, 1, 1, 1, -3, 1);
    cyc("a3", 1, 8'hA3, 1, 1, 1, 1, -4, 0);

    // Back-to-back frame is held off until credit recovers to zero
    cyc("bgate0", 1, 8'hB0, 0, 1, 0, 0, -3, 0);
    cyc("bgate1", 1, 8'hB0, 0, 1, 0, 0, -2, 0);
    cyc("bgate2", 1, 8'hB0, 0, 1, 0, 0, -1, 0);
    cyc("bgate3", 1, 8'hB0, 0, 1, 0, 0, 0, 0);
    cyc("b0", 1, 8'hB0, 0, 1, 1, 1, -1, 1);
    cyc("b1", 1, 8'hB1, 1, 1, 1, 1, -2, 0);

    // Empty queue recovers negative credit
    cyc("e0", 0, 8'h00, 0, 1, 0, 0, -1, 0);
    cyc("e1", 0, 8'h00, 0, 1, 0, 0, 0, 0);

    // Downstream stalls mid-frame; gate held open by frame state
    cyc("c0", 1, 8'hC0, 0, 1, 1, 1, -1, 1);
    cyc("c1s", 1, 8'hC1, 0, 0, 1, 0, 0, 1);
    cyc("c1", 1, 8'hC1, 0, 1, 1, 1, -1, 1);
    cyc("c2s", 1, 8'hC2, 1, 0, 1, 0, 0, 1);
    cyc("c2", 1, 8'hC2, 1, 1, 1, 1, -1, 0);

    // Lower clamp
    min_credit = -32'sd2;
    cyc("e2", 0, 8'h00, 0, 1, 0, 0, 0, 0);
    cyc("d0", 1, 8'hD0, 0, 1, 1, 1, -1, 1);
    cyc("d1", 1, 8'hD1, 0, 1, 1, 1, -2, 1);
    cyc("d2", 1, 8'hD2, 0, 1, 1, 1, -2, 1);
    cyc("d3", 1, 8'hD3, 0, 1, 1, 1, -2, 1);
    cyc("d4", 1, 8'hD4, 1, 1, 1, 1, -2, 0);
    min_credit = 32'h8000_0000;

    // Reach credit 3 with one gated waiting cycle at a larger idle slope
    idle_slope = 32'sd5;
    cyc("w0", 1, 8'hE0, 0, 0, 0, 0, 3, 0);
    idle_slope = 32'sd1;

    // Idle with empty queue from credit 3
    for (int i = 0; i < 10; i++) begin
`ifdef CBS_IDLE_CREDIT_RESET_EN
      exp_cr = 0;
`else
      exp_cr = 4 + i;
`endif
      cyc($sformatf("idle%0d", i), 0, 8'h00, 0, 1, 0, 1, exp_cr, 0);
    end
    chk("idle10.credit", credit, exp_cr);

    // Upper clamp while banking
    max_credit = 32'sd15;
    for (int i = 0; i < 5; i++) begin
`ifdef CBS_IDLE_CREDIT_RESET_EN
      exp_cr = 0;
`else
      exp_cr = (14 + i > 15) ? 15 : 14 + i;
`endif
      cyc($sformatf("max%0d", i), 0, 8'h00, 0, 1, 0, 1, exp_cr, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axis_credit_based_shaper.md
# axis_credit_based_shaper

Credit-based shaper (IEEE 802.1Qav style) for one AXI4-Stream traffic class. It sits between a per-class egress queue and the port's transmit arbiter/MAC. It passes frames through with zero latency when credit allows. It tracks a signed credit that is charged while sending and replenished while waiting, and never cuts a frame mid-transmission.

## Interface
- Reset: one clock `clk`; reset `rstn` is asynchronous and active-low.
- C_AXIS_TDATA_WIDTH, default 8: data width in bits; must be a multiple of 8.
- C_AXIS_TKEEP_WIDTH, default 1: keep width; equals C_AXIS_TDATA_WIDTH/8.
- clk  in  1  clock
- rstn  in  1  async active-low reset
- idle_slope  in  32 signed  credit added per waiting cycle; positive
- send_slope  in  32 signed  credit added per transmitted beat; negative
- max_credit  in  32 signed  upper credit clamp; positive
- min_credit  in  32 signed  lower credit clamp; negative
- credit  out  32 signed  current credit register (debug)
- transmit_until_frame_end  out  1  high while a frame is in progress (debug)
- s_axis_tdata/tkeep/tvalid/tready/tlast  in/in/in/out/in  DATA/KEEP/1/1/1  ingress stream
- m_axis_tdata/tkeep/tvalid/tready/tlast  out/out/out/in/out  DATA/KEEP/1/1/1  egress stream

## Operation
- Gate: `open = transmit_until_frame_end || (credit >= 0)`.
- Data path, combinational pass-through:
  - m_axis_tdata/tkeep/tlast = s_axis_*.
  - m_axis_tvalid = s_axis_tvalid & open.
  - s_axis_tready = m_axis_tready & open.
- Beat accepted ("xfer") = m_axis_tvalid & m_axis_tready.
- transmit_until_frame_end:
  - set on xfer with tlast=0;
  - cleared on xfer with tlast=1;
  - a 1-beat frame leaves it 0.
- Credit update, evaluated each cycle in priority order:
  1. xfer: credit += send_slope.
  2. s_axis_tvalid high without xfer (waiting, including a downstream stall mid-frame): credit += idle_slope.
  3. Queue empty (s_axis_tvalid=0) and credit < 0: credit = min(credit + idle_slope, 0).
  4. Queue empty and credit >= 0: see Configuration.
- Arithmetic is 33-bit signed. The result is clamped to [min_credit, max_credit], so there is no wrap-around. With max=0x7FFFFFFF and min=0x80000000 this gives pure saturation.
- Settings are sampled every cycle. A change takes effect on the next update, and the credit register is not reset.

## Timing
- Zero-cycle data latency; credit updates take effect at the next posedge.
- The gate uses registered credit. A beat that drives credit negative is completed, and the rest of its frame still passes because transmit_until_frame_end holds the gate open.
- Once the gate is open with tvalid high, AXIS rules apply: m_axis_tvalid must not drop until accepted. The gate only closes after a tlast xfer, so this holds.
- Reset, asynchronous:
  - credit = 0, transmit_until_frame_end = 0;
  - m_axis_tvalid and s_axis_tready forced 0 while rstn = 0.
- Reset mid-frame discards frame state; the next beat is treated as a frame start.

## Configuration
- CBS_IDLE_CREDIT_RESET_EN defined: with queue empty and credit > 0, credit is set to 0. This is 802.1Qav behaviour: no burst credit is banked while idle.
- Not defined: with queue empty and credit >= 0, credit += idle_slope, clamped to max_credit, so idle time banks credit for bursts.

## Test plan
Settings idle=1, send=-1, max=0x7FFFFFFF, min=0x80000000 unless noted.
- Reset: hold rstn=0 with s_axis_tvalid=1 -> credit=0, m_axis_tvalid=0, s_axis_tready=0, transmit_until_frame_end=0.
- Single frame: 4-beat frame at credit 0 with tready=1 -> 4 contiguous beats, credit -1,-2,-3,-4; transmit_until_frame_end high after beat 1 through the tlast beat.
- Back-to-back frames: a second frame queued right after the first -> gated; credit rises 1 per cycle to 0, then the frame starts; byte stream is identical to input.
- Downstream stall: random m_axis_tready mid-frame -> no data loss or reorder; credit +1 on stalled cycles, -1 per beat; the frame is never split by the gate.
- Clamp: min_credit=-2, send=-1, 5-beat frame -> credit stops at -2.
- Macro: idle 10 cycles with empty queue from credit 3 -> 0 with CBS_IDLE_CREDIT_RESET_EN, 13 without.
